// File: rtl/sys_defs.sv
// Shared store-queue types and sizing used by the queue and its request engine.
package sys_defs;

  localparam int unsigned SQ_SZ        = 8;
  localparam int unsigned SQ_IDX       = $clog2(SQ_SZ);
  localparam int unsigned SQ_CNT_WIDTH = $clog2(SQ_SZ + 1);
  localparam int unsigned N            = 2;
  localparam int unsigned MEM_SIZE_W   = 2;

  // Access size encoding as presented on the data-memory port.
  typedef logic [MEM_SIZE_W-1:0] MEM_SIZE;

  // Store-FU fill packet: address/data/size for an allocated queue slot.
  typedef struct packed {
    logic              valid;
    logic [SQ_IDX-1:0] sq_idx;
    logic [31:0]       addr;
    logic [31:0]       data;
    MEM_SIZE           size;
  } FU_SQ_PACKET;

  // One queue slot; filled is set once the store FU has delivered addr/data.
  typedef struct packed {
    logic        filled;
    logic [31:0] addr;
    logic [31:0] data;
    MEM_SIZE     size;
  } SQ_ENTRY;

endpackage

// File: rtl/sq_mem_req.sv
// Two-state memory write engine: latches the head store and holds the
// request stable until the memory acknowledges it.
module sq_mem_req
  import sys_defs::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [31:0]           head_addr_i,
  input  logic [31:0]           head_data_i,
  input  logic [MEM_SIZE_W-1:0] head_size_i,
  input  logic                  mem_ack_i,
  input  logic                  squash_i,
  output logic                  mem_req_valid_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [31:0]           mem_req_data_o,
  output logic [MEM_SIZE_W-1:0] mem_req_size_o,
  output logic                  sent_c_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [MEM_SIZE_W-1:0] size_q, size_d;

  // State and request registers; reset drops any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  // Next state: capture head on start, complete on ack, squash forces IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    size_d   = size_q;
    sent_c_o = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = REQ;
        addr_d  = head_addr_i;
        data_d  = head_data_i;
        size_d  = head_size_i;
      end
    end else begin
      if (mem_ack_i) begin
        sent_c_o = 1'b1;
        state_d  = IDLE;
      end
    end
    if (squash_i) begin
      state_d  = IDLE;
      sent_c_o = 1'b0;
    end
  end

  // Request outputs come straight from registered state.
  always_comb begin
    mem_req_valid_o = (state_q == REQ);
    mem_req_addr_o  = addr_q;
    mem_req_data_o  = data_q;
    mem_req_size_o  = size_q;
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, fill from the store FU, drain
// ROB-authorized heads to the data-memory port one at a time.
module store_queue
  import sys_defs::*;
#(
  parameter  int unsigned SIZE        = SQ_SZ,
  parameter  int unsigned N           = sys_defs::N,
  parameter  int unsigned ALERT_DEPTH = N,
  parameter  int unsigned FILL_PORTS  = 1,
  localparam int unsigned IDX_W       = $clog2(SIZE),
  localparam int unsigned CNT_W       = $clog2(SIZE + 1)
)(
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N-1:0]                 dp_valid,
  output logic [N-1:0][IDX_W-1:0]      sq_tail_entries,
  input  FU_SQ_PACKET [FILL_PORTS-1:0] fill,
  input  logic [IDX_W-1:0]             rob_commit_insns_num,
  input  logic                         squash,
  output logic [IDX_W-1:0]             sq_sent_insns_num,
  output logic                         mem_req_valid,
  output logic [31:0]                  mem_req_addr,
  output logic [31:0]                  mem_req_data,
  output logic [MEM_SIZE_W-1:0]        mem_req_size,
  input  logic                         mem_ack,
  output logic                         almost_full,
  output logic [CNT_W-1:0]             counter_out
);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  SQ_ENTRY          entries_q [SIZE];
  SQ_ENTRY          entries_d [SIZE];

  logic [CNT_W-1:0] n_alloc_c;
  logic             alloc_en_c;
  logic             head_ready_c;
  logic             pop_c;

  // Pointer, occupancy and entry storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int unsigned i = 0; i < SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // Occupancy alert and the next N allocation slots depend on state only.
  always_comb begin
    almost_full = (cnt_q > CNT_W'(SIZE - ALERT_DEPTH));
    counter_out = cnt_q;
    for (int unsigned i = 0; i < N; i++) begin
      sq_tail_entries[i] = tail_q + IDX_W'(i);
    end
  end

  assign alloc_en_c = !almost_full && !squash;

  // Head is eligible when present, filled (registered view) and authorized.
  assign head_ready_c = (cnt_q != '0) && entries_q[head_q].filled &&
                        (rob_commit_insns_num != '0);

  // Entry updates: dispatch packs valid lanes from tail, fills mark slots
  // ready, squash invalidates everything.
  always_comb begin
    entries_d = entries_q;
    n_alloc_c = '0;
    if (alloc_en_c) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (dp_valid[i]) begin
          entries_d[tail_q + IDX_W'(n_alloc_c)].filled = 1'b0;
          n_alloc_c = n_alloc_c + CNT_W'(1);
        end
      end
    end
    for (int unsigned p = 0; p < FILL_PORTS; p++) begin
      if (fill[p].valid) begin
        entries_d[IDX_W'(fill[p].sq_idx)].filled = 1'b1;
        entries_d[IDX_W'(fill[p].sq_idx)].addr   = fill[p].addr;
        entries_d[IDX_W'(fill[p].sq_idx)].data   = fill[p].data;
        entries_d[IDX_W'(fill[p].sq_idx)].size   = fill[p].size;
      end
    end
    if (squash) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        entries_d[i].filled = 1'b0;
      end
    end
  end

  // Pointers advance by allocations at tail and the acked pop at head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q + IDX_W'(n_alloc_c);
    cnt_d  = cnt_q + n_alloc_c;
    if (pop_c) begin
      head_d = head_q + IDX_W'(1);
      cnt_d  = cnt_d - CNT_W'(1);
    end
    if (squash) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // Completion count back to the ROB is the ack of the in-flight write.
  assign sq_sent_insns_num = IDX_W'(pop_c);

  sq_mem_req u_mem_req (
    .clock           (clock),
    .reset           (reset),
    .start_i         (head_ready_c),
    .head_addr_i     (entries_q[head_q].addr),
    .head_data_i     (entries_q[head_q].data),
    .head_size_i     (entries_q[head_q].size),
    .mem_ack_i       (mem_ack),
    .squash_i        (squash),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_data_o  (mem_req_data),
    .mem_req_size_o  (mem_req_size),
    .sent_c_o        (pop_c)
  );

endmodule
